pe_act_broadcaster: RTL
=======================

# pe_act_broadcaster

Parametrised activation broadcaster for the PE network interface. On a start pulse it scans the local activation register file over index range [0, act_no) and sends one packet per activation to the router. In sparse mode it sends only nonzero entries; in dense mode it sends every entry. It then sends a lowest-priority finish packet that carries the PE index. It supports a 1-cycle synchronous register-file read, full-throughput valid/ready output through a 2-entry buffer, and abort.

## Interface
- ACT_NO, 64: activation register depth; power of 2, ≥2.
- DATA_W, 16: activation data width; ≥ PE_IDX_W.
- PE_IDX_W, 6: PE index width.
- ADDR_W, 16: router address width; ≥ IDX_W+PE_IDX_W+1.
- Derived: IDX_W = $clog2(ACT_NO) and CNT_W = IDX_W+1.

- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- pe_idx  in  PE_IDX_W  this PE's index; static.
- start  in  1  one-cycle broadcast request; accepted only when idle.
- dense_mode  in  1  sampled with start. 1 = send all indices; 0 = skip zeros.
- abort  in  1  terminates a broadcast in progress.
- act_no  in  CNT_W  number of activations; sampled with start; clamped to ACT_NO.
- act_zero  in  ACT_NO  bit i = 1 means activation i is zero. The PE holds it stable while busy.
- rd_en  out  1  register-file read strobe.
- rd_addr  out  IDX_W  read index.
- rd_data  in  DATA_W  read data, valid in the cycle after rd_en.
- send_valid  out  1  packet valid.
- send_data  out  DATA_W  packet payload.
- send_addr  out  ADDR_W  packet address.
- send_ready  in  1  router accepts the packet when valid && ready.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse after the finish packet is accepted.
- sent_cnt  out  CNT_W  activation packets accepted this broadcast; excludes the finish packet.

## Operation
- States: IDLE, SCAN, DRAIN, FIN.
- Reset: state IDLE, cursor 0, buffer empty. All outputs are 0.
- Start acceptance, IDLE only:
  - On start, latch mode and min(act_no, ACT_NO) as stop.
  - Set cursor = 0 and sent_cnt = 0.
  - Go to SCAN, or to FIN if stop = 0.
  - start in any other state is ignored.
- SCAN, candidate selection:
  - Dense: candidate = cursor, valid while cursor < stop.
  - Sparse: candidate = lowest i in [cursor, stop) with act_zero[i] = 0; valid if one exists.
- SCAN, read issue:
  - Condition: candidate valid && (buffered + in-flight entries) < 2, counting an entry popped this cycle as free.
  - Action: rd_en = 1, rd_addr = candidate, cursor ← candidate+1.
  - If no candidate is valid, go to DRAIN.
- Read return: in the cycle after rd_en, push rd_data into the buffer.
  - The entry's address is {zeros, rd_addr, pe_idx}: bits [PE_IDX_W-1:0] = pe_idx, next IDX_W bits = index, remaining bits 0.
- Buffer output:
  - The 2-entry FIFO drives send_valid, send_data and send_addr.
  - The head is held stable until send_ready.
  - sent_cnt increments on each accepted activation packet.
- DRAIN: when the buffer is empty and no read is in flight, go to FIN.
- FIN:
  - Drive send_valid = 1, send_data = zero-extended pe_idx, send_addr = MSB 1 and all other bits 0.
  - On accept, pulse done for one cycle, go to IDLE, busy = 0.
- Abort, any non-IDLE state:
  - Next cycle: IDLE, buffer flushed, send_valid = 0. Any in-flight rd_data is dropped.
  - No finish packet is sent and done is not asserted.
  - A handshake in the abort cycle still counts toward sent_cnt.
  - A start in the same cycle as abort is ignored.
- sent_cnt holds its value after done or abort until the next accepted start.

## Timing
- Start sampled at edge E0:
  - rd_en first asserts in cycle 1.
  - The data is pushed at the end of cycle 2.
  - send_valid first rises in cycle 3.
- Throughput: with send_ready held high, one activation packet per cycle. There are no bubbles between nonzeros, including in sparse mode.
- Order: packets are sent in strictly ascending index, followed by the finish packet.
- stop = 0: FIN in cycle 1 with send_valid = 1. done follows in the cycle after the accept.
- Backpressure: at most 2 buffered entries plus 0 in-flight reads, or 1 buffered plus 1 in-flight. send_data and send_addr never change while send_valid && !send_ready.
- Index and count arithmetic is in CNT_W bits. cursor = ACT_NO is legal and terminates the scan.
- Reset asserted mid-broadcast: all state and outputs return to their reset values immediately.

## Test plan
- Sparse, ACT_NO=64, act_no=10, nonzeros at {1,4,9}, send_ready=1 → packets at addresses {0,1,pe}, {0,4,pe}, {0,9,pe} on consecutive cycles 3–5. Finish packet follows, then done, then sent_cnt = 3.
- Dense, act_no=4, zeros everywhere → 4 packets for indices 0–3 with their read data, then finish; sent_cnt = 4.
- Sparse, all zeros, act_no=64 → finish packet only (MSB = 1, data = pe_idx); sent_cnt = 0; no rd_en.
- Backpressure: 8 nonzeros, send_ready toggled 1/0 every cycle → all 8 packets in order, no duplicates, and outputs stable while stalled.
- Abort after 2 accepts of 6 → send_valid = 0 the next cycle, no finish packet, no done, sent_cnt = 2, busy = 0.
- start while busy, plus act_no=80 clamped to 64 in dense mode → the busy-time start is ignored; exactly 64 packets plus finish.

Source files
------------

// File: rtl/pe_act_broadcaster.sv
// Activation broadcaster: scans the local activation register file and sends one
// packet per (nonzero or every) activation to the router, then a finish packet.
module pe_act_broadcaster #(
    parameter int ACT_NO   = 64,
    parameter int DATA_W   = 16,
    parameter int PE_IDX_W = 6,
    parameter int ADDR_W   = 16,
    localparam int IDX_W   = $clog2(ACT_NO),
    localparam int CNT_W   = IDX_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PE_IDX_W-1:0] pe_idx,
    input  logic                start,
    input  logic                dense_mode,
    input  logic                abort,
    input  logic [CNT_W-1:0]    act_no,
    input  logic [ACT_NO-1:0]   act_zero,
    output logic                rd_en,
    output logic [IDX_W-1:0]    rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                send_valid,
    output logic [DATA_W-1:0]   send_data,
    output logic [ADDR_W-1:0]   send_addr,
    input  logic                send_ready,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    sent_cnt
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cursor, stop, stop_in;
    logic                dense_r;
    logic                inflight;
    logic [IDX_W-1:0]    inflight_idx;
    logic [DATA_W-1:0]   buf_data [2];
    logic [ADDR_W-1:0]   buf_addr [2];
    logic                rd_ptr, wr_ptr;
    logic [1:0]          count;
    logic                cand_valid;
    logic [IDX_W-1:0]    cand_idx;
    logic                pop, push, start_ok, fin_accept;
    logic [2:0]          occ;
    logic [ADDR_W-1:0]   fin_addr;

    assign stop_in  = (act_no > CNT_W'(ACT_NO)) ? CNT_W'(ACT_NO) : act_no;
    assign fin_addr = {1'b1, {(ADDR_W-1){1'b0}}};

    // Lowest eligible index in [cursor, stop); dense mode takes the cursor itself.
    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = '0;
        if (dense_r) begin
            cand_valid = (cursor < stop);
            cand_idx   = cursor[IDX_W-1:0];
        end else begin
            for (int unsigned i = 0; i < ACT_NO; i++) begin
                if (!cand_valid && !act_zero[i] && CNT_W'(i) >= cursor && CNT_W'(i) < stop) begin
                    cand_valid = 1'b1;
                    cand_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign pop  = (count != 2'd0) && send_ready;
    assign push = inflight;
    // A slot freed by this cycle's pop can be refilled at once, giving full throughput.
    assign occ  = 3'(count) + 3'(inflight) - 3'(pop);

    assign busy       = (state != IDLE);
    assign send_valid = (state == FIN) || (count != 2'd0);
    assign send_data  = (state == FIN) ? DATA_W'(pe_idx) :
                        (count != 2'd0) ? buf_data[rd_ptr] : '0;
    assign send_addr  = (state == FIN) ? fin_addr :
                        (count != 2'd0) ? buf_addr[rd_ptr] : '0;

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        rd_addr    = '0;
        start_ok   = 1'b0;
        fin_accept = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = (stop_in == '0) ? FIN : SCAN;
                end
            end
            SCAN: begin
                if (cand_valid) begin
                    if (occ < 3'd2) begin
                        rd_en   = 1'b1;
                        rd_addr = cand_idx;
                    end
                end else begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (count == 2'd0 && !inflight) state_next = FIN;
            end
            FIN: begin
                if (send_ready) begin
                    fin_accept = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            rd_en      = 1'b0;
            rd_addr    = '0;
            start_ok   = 1'b0;
            fin_accept = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor       <= '0;
            stop         <= '0;
            dense_r      <= 1'b0;
            inflight     <= 1'b0;
            inflight_idx <= '0;
            done         <= 1'b0;
            sent_cnt     <= '0;
        end else begin
            done     <= fin_accept;
            inflight <= rd_en;
            if (start_ok) begin
                dense_r  <= dense_mode;
                stop     <= stop_in;
                cursor   <= '0;
                sent_cnt <= '0;
            end
            if (rd_en) begin
                cursor       <= CNT_W'(cand_idx) + CNT_W'(1);
                inflight_idx <= cand_idx;
            end
            if (pop) sent_cnt <= sent_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= '0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_addr[0] <= '0;
            buf_addr[1] <= '0;
        end else if (abort) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= rd_data;
                buf_addr[wr_ptr] <= ADDR_W'({inflight_idx, pe_idx});
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= 2'(count + {1'b0, push} - {1'b0, pop});
        end
    end

endmodule
